desc_mem_arbiter: RTL and testbench

DESC_MEM_ARBITER -- requirements
Module: desc_mem_arbiter

---
 rtl/desc_mem_arbiter_pkg.sv | 22 ++
 rtl/desc_mem_arbiter_if.sv | 49 ++++
 rtl/desc_mem_arbiter_rr.sv | 21 ++
 rtl/desc_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_desc_mem_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/desc_mem_arbiter_pkg.sv
// Shared types and default sizes for the two-requester descriptor memory arbiter.
// Imported by the interfaces, the round-robin sub-module and the top.
package desc_mem_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_LOCK_MAX = 16;
    localparam int LOCK_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    typedef logic req_idx_t;

    function automatic arb_state_e own_state(req_idx_t idx);
        return idx ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/desc_mem_arbiter_if.sv
// Requester-side bus (Avalon-style with lock) and single-port RAM command bus
// used as ports of desc_mem_arbiter.
import desc_mem_pkg::*;

interface desc_req_if #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                lock;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata, lock,
        input  waitrequest, readdata, readdatavalid
    );
    modport slave (
        input  address, byteenable, read, write, writedata, lock,
        output waitrequest, readdata, readdatavalid
    );
endinterface

interface desc_mem_if #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic                chipselect;
    logic                write;
    logic                clken;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output address, byteenable, writedata, chipselect, write, clken,
        input  readdata
    );
    modport slave (
        input  address, byteenable, writedata, chipselect, write, clken,
        output readdata
    );
endinterface

// File: rtl/desc_mem_arbiter_rr.sv
// Two-way round-robin decision: on contention the requester not granted last wins,
// a lone requester wins immediately.
module desc_rr_arb2
    import desc_mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_idx_t   last_i,
    output logic [1:0] gnt_o
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        gnt_o = '0;
        if (&req_i) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/desc_mem_arbiter.sv
// Arbitrates two lock-capable requesters onto one single-port RAM (read latency 1).
// Optional DESC_ARB_STATS_EN adds saturating grant and contention counters.
module desc_mem_arbiter
    import desc_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic        clk,
    input  logic        reset,
    desc_req_if.slave   m0,
    desc_req_if.slave   m1,
    desc_mem_if.master  mem
`ifdef DESC_ARB_STATS_EN
    ,
    output logic [15:0] stats0_grants,
    output logic [15:0] stats1_grants,
    output logic [15:0] stats_contention
`endif
);

    arb_state_e            state_q, state_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    req_idx_t              last_q, last_d;
    logic [1:0]            rdv_q, rdv_d;

    logic [1:0]          want, rr_gnt, gnt;
    req_idx_t            gnt_idx;
    logic                accept, gnt_lock, gnt_write;
    logic [ADDR_W-1:0]   addr_sel;
    logic [DATA_W-1:0]   wdata_sel;
    logic [DATA_W/8-1:0] be_sel;

    assign want = {m1.read | m1.write, m0.read | m0.write};

    desc_rr_arb2 u_rr (
        .req_i  (want),
        .last_i (last_q),
        .gnt_o  (rr_gnt)
    );

    always_comb begin
        gnt        = '0;
        state_d    = state_q;
        lock_cnt_d = '0;
        case (state_q)
            ST_IDLE: gnt = rr_gnt;
            ST_OWN0: begin
                gnt        = {1'b0, want[0]};
                lock_cnt_d = lock_cnt_q + 1'b1;
                if (!m0.lock || lock_cnt_d == LOCK_CNT_W'(LOCK_MAX)) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end
            end
            ST_OWN1: begin
                gnt        = {want[1], 1'b0};
                lock_cnt_d = lock_cnt_q + 1'b1;
                if (!m1.lock || lock_cnt_d == LOCK_CNT_W'(LOCK_MAX)) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Nothing is accepted while reset is held, so no stray RAM access or read return.
        if (reset) begin
            gnt = '0;
        end

        accept    = |gnt;
        gnt_idx   = gnt[1];
        gnt_lock  = gnt_idx ? m1.lock  : m0.lock;
        gnt_write = gnt_idx ? m1.write : m0.write;

        // After a forced release last_q still names the holder, so the round-robin
        // already hands the next contended grant to the other requester.
        if (state_q == ST_IDLE && accept && gnt_lock) begin
            state_d = own_state(gnt_idx);
        end

        last_d = accept ? gnt_idx : last_q;
        rdv_d  = gnt & {m1.read & ~m1.write, m0.read & ~m0.write};
    end

    assign addr_sel  = gnt_idx ? m1.address    : m0.address;
    assign wdata_sel = gnt_idx ? m1.writedata  : m0.writedata;
    assign be_sel    = gnt_idx ? m1.byteenable : m0.byteenable;

    assign mem.address    = addr_sel;
    assign mem.writedata  = wdata_sel;
    assign mem.byteenable = be_sel;
    assign mem.chipselect = accept;
    assign mem.write      = accept & gnt_write;
    assign mem.clken      = 1'b1;

    assign m0.waitrequest   = ~gnt[0];
    assign m1.waitrequest   = ~gnt[1];
    assign m0.readdata      = mem.readdata;
    assign m1.readdata      = mem.readdata;
    assign m0.readdatavalid = rdv_q[0];
    assign m1.readdatavalid = rdv_q[1];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
            last_q     <= 1'b1;
            rdv_q      <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            last_q     <= last_d;
            rdv_q      <= rdv_d;
        end
    end

`ifdef DESC_ARB_STATS_EN
    logic [15:0] grants0_q, grants1_q, contention_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            grants0_q    <= '0;
            grants1_q    <= '0;
            contention_q <= '0;
        end else begin
            if (gnt[0] && grants0_q != 16'hFFFF) grants0_q <= grants0_q + 1'b1;
            if (gnt[1] && grants1_q != 16'hFFFF) grants1_q <= grants1_q + 1'b1;
            if (&want && contention_q != 16'hFFFF) contention_q <= contention_q + 1'b1;
        end
    end

    assign stats0_grants    = grants0_q;
    assign stats1_grants    = grants1_q;
    assign stats_contention = contention_q;
`endif

endmodule

// File: tb/tb_desc_mem_arbiter.sv
// Self-checking bench for desc_mem_arbiter: directed scenarios plus randomized
// traffic, all scored against a cycle-level behavioural model of the arbiter rules.
module tb_desc_mem_arbiter;

    localparam int LOCK_MAX = 16;

    typedef struct {
        bit        rd;
        bit        wr;
        bit        lk;
        bit [9:0]  addr;
        bit [31:0] wdata;
        bit [3:0]  be;
    } req_t;

    logic clk;
    logic rst;

    desc_req_if #(.ADDR_W(10), .DATA_W(32)) m0_if ();
    desc_req_if #(.ADDR_W(10), .DATA_W(32)) m1_if ();
    desc_mem_if #(.ADDR_W(10), .DATA_W(32)) mem_if ();

`ifdef DESC_ARB_STATS_EN
    logic [15:0] s0_grants, s1_grants, s_contention;
`endif

    desc_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .LOCK_MAX(LOCK_MAX)) dut (
        .clk   (clk),
        .reset (rst),
        .m0    (m0_if),
        .m1    (m1_if),
        .mem   (mem_if)
`ifdef DESC_ARB_STATS_EN
        ,
        .stats0_grants    (s0_grants),
        .stats1_grants    (s1_grants),
        .stats_contention (s_contention)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment RAM: latency-1 single-port memory; unwritten words return a fixed pattern.
    bit [31:0] ram [1024];
    bit        ram_written [1024];

    function automatic bit [31:0] init_word(int a);
        return 32'hC0DE0000 | 32'(a);
    endfunction

    always @(posedge clk) begin
        if (mem_if.chipselect) begin
            if (mem_if.write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_if.byteenable[b]) begin
                        ram[mem_if.address][8*b +: 8] <= mem_if.writedata[8*b +: 8];
                    end else if (!ram_written[mem_if.address]) begin
                        ram[mem_if.address][8*b +: 8] <= init_word(int'(mem_if.address)) >> (8*b);
                    end
                end
                ram_written[mem_if.address] <= 1'b1;
            end
            mem_if.readdata <= ram_written[mem_if.address] ? ram[mem_if.address]
                                                           : init_word(int'(mem_if.address));
        end
    end

    // Stimulus and reference model state
    req_t      rq [2];
    bit        rst_v;
    int        checks;
    int        failures;

    int        own;
    int        own_cnt;
    int        last;
    bit        exp_rdv [2];
    bit [31:0] exp_rdata [2];
    bit [31:0] model_mem [1024];
    int        acc_cnt [2];
    int        cont_cnt;

    int        obs_g;
    bit        obs_rdv [2];
    bit [31:0] obs_rdata [2];

    task automatic note_fail(string name, string detail);
        failures++;
        if (failures <= 40) $display("FAIL %s %s", name, detail);
    endtask

    task automatic drive();
        rst                = rst_v;
        m0_if.read         = rq[0].rd;
        m0_if.write        = rq[0].wr;
        m0_if.lock         = rq[0].lk;
        m0_if.address      = rq[0].addr;
        m0_if.writedata    = rq[0].wdata;
        m0_if.byteenable   = rq[0].be;
        m1_if.read         = rq[1].rd;
        m1_if.write        = rq[1].wr;
        m1_if.lock         = rq[1].lk;
        m1_if.address      = rq[1].addr;
        m1_if.writedata    = rq[1].wdata;
        m1_if.byteenable   = rq[1].be;
    endtask

    task automatic set_req(int n, bit rd, bit wr, bit lk, int addr, bit [31:0] wdata);
        rq[n].rd    = rd;
        rq[n].wr    = wr;
        rq[n].lk    = lk;
        rq[n].addr  = 10'(addr);
        rq[n].wdata = wdata;
        rq[n].be    = 4'hF;
    endtask

    task automatic idle_all();
        set_req(0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);
    endtask

    // One clock cycle: apply inputs, score DUT outputs against the model, advance the model.
    task automatic step();
        int g;
        bit want [2];
        drive();
        @(negedge clk);
        obs_g        = !m0_if.waitrequest ? 0 : (!m1_if.waitrequest ? 1 : -1);
        obs_rdv[0]   = m0_if.readdatavalid;
        obs_rdv[1]   = m1_if.readdatavalid;
        obs_rdata[0] = m0_if.readdata;
        obs_rdata[1] = m1_if.readdata;

        for (int n = 0; n < 2; n++) want[n] = rq[n].rd | rq[n].wr;
        if (rst_v) g = -1;
        else if (own < 0) begin
            if (want[0] && want[1]) g = 1 - last;
            else if (want[0])       g = 0;
            else if (want[1])       g = 1;
            else                    g = -1;
        end else g = want[own] ? own : -1;

        checks++;
        if (m0_if.waitrequest !== (g != 0))
            note_fail("m0_waitrequest", $sformatf("got=%b want=%b t=%0t", m0_if.waitrequest, g != 0, $time));
        checks++;
        if (m1_if.waitrequest !== (g != 1))
            note_fail("m1_waitrequest", $sformatf("got=%b want=%b t=%0t", m1_if.waitrequest, g != 1, $time));
        checks++;
        if (mem_if.chipselect !== (g >= 0))
            note_fail("mem_chipselect", $sformatf("got=%b want=%b t=%0t", mem_if.chipselect, g >= 0, $time));
        checks++;
        if (mem_if.write !== (g >= 0 && rq[g < 0 ? 0 : g].wr))
            note_fail("mem_write", $sformatf("got=%b t=%0t", mem_if.write, $time));
        checks++;
        if (mem_if.clken !== 1'b1)
            note_fail("mem_clken", $sformatf("got=%b want=1", mem_if.clken));
        if (g >= 0) begin
            checks++;
            if (mem_if.address !== rq[g].addr)
                note_fail("mem_address", $sformatf("got=%h want=%h t=%0t", mem_if.address, rq[g].addr, $time));
            if (rq[g].wr) begin
                checks++;
                if (mem_if.writedata !== rq[g].wdata || mem_if.byteenable !== rq[g].be)
                    note_fail("mem_wdata", $sformatf("got=%h/%h want=%h/%h", mem_if.writedata,
                              mem_if.byteenable, rq[g].wdata, rq[g].be));
            end
        end
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (obs_rdv[n] !== exp_rdv[n])
                note_fail($sformatf("m%0d_readdatavalid", n),
                          $sformatf("got=%b want=%b t=%0t", obs_rdv[n], exp_rdv[n], $time));
            if (exp_rdv[n]) begin
                checks++;
                if (obs_rdata[n] !== exp_rdata[n])
                    note_fail($sformatf("m%0d_readdata", n),
                              $sformatf("got=%h want=%h t=%0t", obs_rdata[n], exp_rdata[n], $time));
            end
        end

        exp_rdv[0] = 0;
        exp_rdv[1] = 0;
        if (rst_v) begin
            own = -1; own_cnt = 0; last = 1;
            acc_cnt[0] = 0; acc_cnt[1] = 0; cont_cnt = 0;
        end else begin
            if (want[0] && want[1]) cont_cnt++;
            if (g >= 0) begin
                last = g;
                acc_cnt[g]++;
                if (rq[g].wr) begin
                    for (int b = 0; b < 4; b++)
                        if (rq[g].be[b]) model_mem[rq[g].addr][8*b +: 8] = rq[g].wdata[8*b +: 8];
                end else begin
                    exp_rdv[g]   = 1;
                    exp_rdata[g] = model_mem[rq[g].addr];
                end
            end
            if (own < 0) begin
                if (g >= 0 && rq[g].lk) begin own = g; own_cnt = 0; end
            end else begin
                own_cnt++;
                if (!rq[own].lk || own_cnt == LOCK_MAX) begin own = -1; own_cnt = 0; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_v = 1;
        set_req(0, 1, 0, 0, 5, 0);
        set_req(1, 0, 1, 0, 6, 32'h1234);
        step();
        checks++;
        if (obs_g !== -1) note_fail("reset_no_grant", $sformatf("got=%0d want=-1", obs_g));
        step();
        rst_v = 0;
        idle_all();
        step();
        checks++;
        if (obs_rdv[0] !== 0 || obs_rdv[1] !== 0)
            note_fail("reset_rdv_low", $sformatf("got=%b%b want=00", obs_rdv[1], obs_rdv[0]));
    endtask

    task automatic test_write_read();
        set_req(0, 0, 1, 0, 3, 32'hDEADBEEF);
        step();
        checks++;
        if (obs_g !== 0) note_fail("wr_grant_m0", $sformatf("got=%0d want=0", obs_g));
        idle_all();
        set_req(1, 1, 0, 0, 3, 0);
        step();
        checks++;
        if (obs_g !== 1 || obs_rdv[1] !== 0)
            note_fail("rd_accept_m1", $sformatf("got=%0d/%b want=1/0", obs_g, obs_rdv[1]));
        idle_all();
        step();
        checks++;
        if (obs_rdv[1] !== 1 || obs_rdata[1] !== 32'hDEADBEEF || obs_rdv[0] !== 0)
            note_fail("rd_return_m1", $sformatf("got=%b/%h want=1/deadbeef", obs_rdv[1], obs_rdata[1]));
    endtask

    task automatic test_alternate();
        rst_v = 1;
        idle_all();
        step();
        rst_v = 0;
        for (int i = 0; i < 12; i++) begin
            set_req(0, 1, 0, 0, 'h20 + i, 0);
            set_req(1, 1, 0, 0, 'h30 + i, 0);
            step();
            checks++;
            if (obs_g !== i % 2)
                note_fail("alt_grant", $sformatf("cycle=%0d got=%0d want=%0d", i, obs_g, i % 2));
            if (i > 0) begin
                checks++;
                if (obs_rdv[(i - 1) % 2] !== 1 || obs_rdv[i % 2] !== 0)
                    note_fail("alt_rdv_tag", $sformatf("cycle=%0d got=%b%b", i, obs_rdv[1], obs_rdv[0]));
            end
        end
        idle_all();
        step();
    endtask

    task automatic test_lock();
        int m1_acc = 0;
        int m0_stall = 0;
        set_req(0, 1, 0, 0, 'h40, 0);
        step();
        for (int k = 0; k < 8; k++) begin
            set_req(1, 1, 0, k < 7, 'h10 + k, 0);
            set_req(0, 1, 0, 0, 'h41, 0);
            step();
            if (obs_g == 1) m1_acc++;
            if (obs_g != 0) m0_stall++;
        end
        checks++;
        if (m1_acc !== 8 || m0_stall !== 8)
            note_fail("lock_m1_burst", $sformatf("got=%0d/%0d want=8/8", m1_acc, m0_stall));
        set_req(1, 0, 0, 0, 0, 0);
        step();
        checks++;
        if (obs_g !== 0) note_fail("lock_release_m0", $sformatf("got=%0d want=0", obs_g));
        idle_all();
        step();
    endtask

    task automatic test_lock_max();
        int g_log [40];
        int m0_run = 0;
        idle_all();
        set_req(1, 1, 0, 0, 'h50, 0);
        step();
        for (int c = 0; c < 40; c++) begin
            set_req(0, 1, 0, 1, 'h60 + (c % 8), 0);
            set_req(1, 1, 0, 0, 'h70, 0);
            step();
            g_log[c] = obs_g;
        end
        for (int c = 0; c <= LOCK_MAX; c++) if (g_log[c] == 0) m0_run++;
        checks++;
        if (m0_run !== LOCK_MAX + 1)
            note_fail("lockmax_hold", $sformatf("got=%0d want=%0d", m0_run, LOCK_MAX + 1));
        checks++;
        if (g_log[LOCK_MAX + 1] !== 1)
            note_fail("lockmax_m1_next", $sformatf("got=%0d want=1", g_log[LOCK_MAX + 1]));
        checks++;
        if (g_log[LOCK_MAX + 2] !== 0 || g_log[LOCK_MAX + 3] !== 0)
            note_fail("lockmax_m0_again", $sformatf("got=%0d,%0d want=0,0", g_log[LOCK_MAX + 2], g_log[LOCK_MAX + 3]));
        idle_all();
        set_req(0, 1, 0, 0, 'h61, 0);
        step();
        idle_all();
        step();
    endtask

    task automatic test_reset_mid();
        set_req(0, 1, 0, 0, 'h12, 0);
        step();
        rst_v = 1;
        set_req(0, 1, 0, 0, 'h12, 0);
        set_req(1, 1, 0, 0, 'h13, 0);
        step();
        rst_v = 0;
        step();
        checks++;
        if (obs_rdv[0] !== 0 || obs_rdv[1] !== 0)
            note_fail("rstmid_no_rdv", $sformatf("got=%b%b want=00", obs_rdv[1], obs_rdv[0]));
        checks++;
        if (obs_g !== 0) note_fail("rstmid_tie_m0", $sformatf("got=%0d want=0", obs_g));
        idle_all();
        step();
    endtask

    task automatic test_random();
        bit lk_st [2];
        for (int c = 0; c < 600; c++) begin
            rst_v = ($urandom_range(0, 99) == 0);
            for (int n = 0; n < 2; n++) begin
                int kind = $urandom_range(0, 9);
                if ($urandom_range(0, 7) == 0) lk_st[n] = ~lk_st[n];
                set_req(n, kind >= 4 && kind != 7 && kind != 8, kind >= 7, lk_st[n],
                        $urandom_range(0, 31), $urandom);
                rq[n].be = 4'($urandom_range(0, 15));
            end
            step();
        end
        rst_v = 0;
        idle_all();
        step();
    endtask

`ifdef DESC_ARB_STATS_EN
    task automatic test_stats();
        rst_v = 1;
        idle_all();
        step();
        rst_v = 0;
        for (int i = 0; i < 10; i++) begin
            set_req(0, 1, 0, 0, i, 0);
            set_req(1, 1, 0, 0, 'h100 + i, 0);
            step();
        end
        idle_all();
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1, 0, 0, 'h200 + i, 0);
            step();
        end
        checks++;
        if (s_contention !== 16'd10)
            note_fail("stats_contention", $sformatf("got=%0d want=10", s_contention));
        checks++;
        if (32'(s0_grants) + 32'(s1_grants) !== 32'd13)
            note_fail("stats_sum", $sformatf("got=%0d want=13", 32'(s0_grants) + 32'(s1_grants)));
        checks++;
        if (s0_grants !== 16'(acc_cnt[0]) || s1_grants !== 16'(acc_cnt[1]) || acc_cnt[0] != 8)
            note_fail("stats_split", $sformatf("got=%0d/%0d want=%0d/%0d", s0_grants, s1_grants,
                      acc_cnt[0], acc_cnt[1]));
        idle_all();
        step();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        own      = -1;
        own_cnt  = 0;
        last     = 1;
        cont_cnt = 0;
        for (int i = 0; i < 1024; i++) model_mem[i] = init_word(i);
        rst_v = 1;
        idle_all();
        drive();
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_alternate();
        test_lock();
        test_lock_max();
        test_reset_mid();
        test_random();
`ifdef DESC_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
